// File: rtl/bp_update_scheduler_pkg.sv
// Shared defaults and update record for the local branch predictor and its
// update scheduler.
package bp_pkg;

    localparam int BP_PC_BITS   = 7;
    localparam int BP_DEPTH     = 4;
    localparam int BP_MAX_DEFER = 2;

    typedef struct packed {
        logic [BP_PC_BITS-1:0] pc;
        logic                  taken;
    } bp_update_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Resolve-side handshake, fetch lookup and predictor write port of the
// update scheduler. master = surrounding pipeline, slave = scheduler.
interface bp_update_scheduler_if
    import bp_pkg::*;
#(
    parameter int PC_BITS = BP_PC_BITS,
    parameter int DEPTH   = BP_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               resolve_valid;
    logic [PC_BITS-1:0] resolve_pc_bits;
    logic               resolve_taken;
    logic               resolve_ready;
    logic               fetch_valid;
    logic [PC_BITS-1:0] fetch_pc_bits;
    logic [PC_BITS-1:0] pc_bits_read;
    logic               write_enabled;
    logic [PC_BITS-1:0] pc_bits_write;
    logic               outcome;
    logic [CW-1:0]      pending;
    logic               fetch_hazard;

    modport master (
        output resolve_valid, resolve_pc_bits, resolve_taken,
        output fetch_valid, fetch_pc_bits,
        input  resolve_ready, pc_bits_read, write_enabled,
        input  pc_bits_write, outcome, pending, fetch_hazard
    );

    modport slave (
        input  resolve_valid, resolve_pc_bits, resolve_taken,
        input  fetch_valid, fetch_pc_bits,
        output resolve_ready, pc_bits_read, write_enabled,
        output pc_bits_write, outcome, pending, fetch_hazard
    );

endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// Circular update queue: storage, pointers, occupancy, head and per-entry
// valid mask so the parent can search all live entries.
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          entry_vld,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign entries = mem_q;

    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [AW-1:0] off;
        assign off          = AW'(i) - rd_ptr_q;
        assign entry_vld[i] = ({1'b0, off} < count_q);
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Serializes resolved-branch updates onto the predictor write port, deferring
// the head (bounded) while fetch reads the same index.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH     = BP_DEPTH,
    parameter int PC_BITS   = BP_PC_BITS,
    parameter int MAX_DEFER = BP_MAX_DEFER
) (
    input  logic                  clk,
    input  logic                  reset,
    bp_update_scheduler_if.slave  bus
);
    localparam int W  = PC_BITS + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);
    localparam logic [DW-1:0] DEFER_ONE = DW'(1);

    logic [W-1:0]              head_raw;
    logic [DEPTH-1:0][W-1:0]   entries;
    logic [DEPTH-1:0]          entry_vld;
    logic [CW-1:0]             count;
    logic                      full, empty;
    logic                      push, wr_en, defer, head_match;
    logic [PC_BITS-1:0]        head_pc;
    logic                      head_taken;
    logic [DEPTH-1:0]          hit;
    logic [DW-1:0]             defer_cnt_q, defer_cnt_d;

    assign push = bus.resolve_valid && !full;

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .din       ({bus.resolve_pc_bits, bus.resolve_taken}),
        .pop       (wr_en),
        .head      (head_raw),
        .entries   (entries),
        .entry_vld (entry_vld),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign head_pc    = head_raw[W-1:1];
    assign head_taken = head_raw[0];

    // The reset gate keeps a queued head from strobing the predictor while
    // the queue is being discarded.
    always_comb begin
        head_match  = bus.fetch_valid && (bus.fetch_pc_bits == head_pc);
        defer       = head_match && (defer_cnt_q < DEFER_MAX) && !empty;
        wr_en       = !reset && !empty && !defer;
        defer_cnt_d = defer_cnt_q;
        if (empty || wr_en) begin
            defer_cnt_d = '0;
        end else if (defer) begin
            defer_cnt_d = defer_cnt_q + DEFER_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            defer_cnt_q <= '0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = entry_vld[i] && (entries[i][W-1:1] == bus.fetch_pc_bits);
    end

    assign bus.resolve_ready = !full;
    assign bus.pc_bits_read  = bus.fetch_pc_bits;
    assign bus.write_enabled = wr_en;
    assign bus.pc_bits_write = head_pc;
    assign bus.outcome       = head_taken;
    assign bus.pending       = count;
    assign bus.fetch_hazard  = bus.fetch_valid && (|hit);

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: drive after each rising edge,
// check combinational/registered outputs a step later.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bp_update_scheduler_if #(.PC_BITS(7), .DEPTH(4)) bif ();

    bp_update_scheduler #(
        .DEPTH     (4),
        .PC_BITS   (7),
        .MAX_DEFER (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [6:0] p, input logic t);
        bif.resolve_valid   = v;
        bif.resolve_pc_bits = p;
        bif.resolve_taken   = t;
    endtask

    initial begin
        logic [6:0] exp_pc;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        offer(1'b0, 7'h00, 1'b0);
        bif.fetch_valid   = 1'b0;
        bif.fetch_pc_bits = 7'h00;
        tick();
        tick();
        chk("rst_we_during", 32'(bif.write_enabled), 0);
        chk("rst_pending", 32'(bif.pending), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bif.resolve_ready), 1);
        chk("rst_pcw", 32'(bif.pc_bits_write), 0);
        chk("rst_outcome", 32'(bif.outcome), 0);
        chk("rst_we", 32'(bif.write_enabled), 0);

        // single update, 1-cycle latency
        offer(1'b1, 7'h12, 1'b1); #1;
        chk("t1_no_bypass", 32'(bif.write_enabled), 0);
        tick(); offer(1'b0, 7'h00, 1'b0); #1;
        chk("t1_we", 32'(bif.write_enabled), 1);
        chk("t1_pcw", 32'(bif.pc_bits_write), 32'h12);
        chk("t1_outcome", 32'(bif.outcome), 1);
        chk("t1_pending1", 32'(bif.pending), 1);
        tick(); #1;
        chk("t1_pending0", 32'(bif.pending), 0);
        chk("t1_we_idle", 32'(bif.write_enabled), 0);

        // bounded defer: 2 deferred cycles then forced write
        bif.fetch_valid = 1'b1; bif.fetch_pc_bits = 7'h05;
        offer(1'b1, 7'h05, 1'b1); #1;
        chk("t3_we_empty", 32'(bif.write_enabled), 0);
        tick(); offer(1'b0, 7'h00, 1'b0); #1;
        chk("t3_pending", 32'(bif.pending), 1);
        chk("t3_defer1", 32'(bif.write_enabled), 0);
        chk("t3_hazard", 32'(bif.fetch_hazard), 1);
        chk("t3_pcw", 32'(bif.pc_bits_write), 32'h05);
        chk("t3_read", 32'(bif.pc_bits_read), 32'h05);
        tick(); #1;
        chk("t3_defer2", 32'(bif.write_enabled), 0);
        tick(); #1;
        chk("t3_forced_we", 32'(bif.write_enabled), 1);
        chk("t3_forced_out", 32'(bif.outcome), 1);
        tick(); #1;
        chk("t3_drained", 32'(bif.pending), 0);

        // fill to full under continuous fetch match; full blocks same-cycle enqueue
        offer(1'b1, 7'h05, 1'b0); #1;                      // A
        chk("t2_ready_a", 32'(bif.resolve_ready), 1);
        tick(); offer(1'b1, 7'h05, 1'b1); #1;              // B
        chk("t2_pend1", 32'(bif.pending), 1);
        chk("t3_cnt_cleared", 32'(bif.write_enabled), 0);
        tick(); offer(1'b1, 7'h05, 1'b0); #1;              // C
        chk("t2_pend2", 32'(bif.pending), 2);
        chk("t2_defer_c", 32'(bif.write_enabled), 0);
        tick(); offer(1'b1, 7'h05, 1'b1); #1;              // D
        chk("t2_pend3", 32'(bif.pending), 3);
        chk("t2_we_a", 32'(bif.write_enabled), 1);
        chk("t2_out_a", 32'(bif.outcome), 0);
        tick(); offer(1'b1, 7'h05, 1'b0); #1;              // E
        chk("t2_pend3b", 32'(bif.pending), 3);
        chk("t2_defer_b", 32'(bif.write_enabled), 0);
        chk("t2_out_b_held", 32'(bif.outcome), 1);
        tick(); offer(1'b1, 7'h05, 1'b1); #1;              // F offered while full
        chk("t2_pend4", 32'(bif.pending), 4);
        chk("t2_not_ready", 32'(bif.resolve_ready), 0);
        chk("t2_defer_b2", 32'(bif.write_enabled), 0);
        tick(); #1;
        chk("t4_pend4", 32'(bif.pending), 4);
        chk("t4_not_ready", 32'(bif.resolve_ready), 0);
        chk("t4_we_b", 32'(bif.write_enabled), 1);
        chk("t4_out_b", 32'(bif.outcome), 1);
        tick(); #1;
        chk("t4_pend3", 32'(bif.pending), 3);
        chk("t4_ready", 32'(bif.resolve_ready), 1);
        chk("t4_defer_c", 32'(bif.write_enabled), 0);
        chk("t4_out_c", 32'(bif.outcome), 0);
        tick(); offer(1'b0, 7'h00, 1'b0); bif.fetch_valid = 1'b0; #1;
        chk("t4_pend4_f", 32'(bif.pending), 4);
        chk("t4_we_c", 32'(bif.write_enabled), 1);
        chk("t4_out_c2", 32'(bif.outcome), 0);
        tick(); #1;
        chk("t4_out_d", 32'(bif.outcome), 1);
        chk("t4_pend3b", 32'(bif.pending), 3);
        tick(); #1;
        chk("t4_out_e", 32'(bif.outcome), 0);
        chk("t4_pend2", 32'(bif.pending), 2);
        tick(); #1;
        chk("t4_out_f", 32'(bif.outcome), 1);
        chk("t4_we_f", 32'(bif.write_enabled), 1);
        tick(); #1;
        chk("t4_empty", 32'(bif.pending), 0);
        chk("t4_we_empty", 32'(bif.write_enabled), 0);

        // mid-operation reset with 3 queued entries
        bif.fetch_valid = 1'b1; bif.fetch_pc_bits = 7'h30;
        offer(1'b1, 7'h30, 1'b0);
        tick(); offer(1'b1, 7'h31, 1'b1); #1;
        chk("t5_defer", 32'(bif.write_enabled), 0);
        tick(); offer(1'b1, 7'h32, 1'b0);
        tick(); offer(1'b0, 7'h00, 1'b0); reset = 1'b1; #1;
        chk("t5_pend3", 32'(bif.pending), 3);
        chk("t5_we_in_reset", 32'(bif.write_enabled), 0);
        tick(); reset = 1'b0; #1;
        chk("t5_pend0", 32'(bif.pending), 0);
        chk("t5_we0", 32'(bif.write_enabled), 0);
        chk("t5_ready", 32'(bif.resolve_ready), 1);
        chk("t5_pcw0", 32'(bif.pc_bits_write), 0);
        tick(); #1;
        chk("t5_no_stale", 32'(bif.write_enabled), 0);
        chk("t5_pend0b", 32'(bif.pending), 0);

        // hazard on a non-head entry does not defer the head
        bif.fetch_pc_bits = 7'h01;
        offer(1'b1, 7'h01, 1'b1);
        tick(); offer(1'b1, 7'h7F, 1'b0); #1;
        chk("t6_defer01", 32'(bif.write_enabled), 0);
        tick(); offer(1'b0, 7'h00, 1'b0); bif.fetch_pc_bits = 7'h7F; #1;
        chk("t6_pend2", 32'(bif.pending), 2);
        chk("t6_hazard", 32'(bif.fetch_hazard), 1);
        chk("t6_we01", 32'(bif.write_enabled), 1);
        chk("t6_pcw01", 32'(bif.pc_bits_write), 32'h01);
        chk("t6_out01", 32'(bif.outcome), 1);
        tick(); #1;
        chk("t6_defer7f", 32'(bif.write_enabled), 0);
        chk("t6_pcw7f", 32'(bif.pc_bits_write), 32'h7F);
        chk("t6_hazard7f", 32'(bif.fetch_hazard), 1);
        bif.fetch_valid = 1'b0; #1;
        chk("t6_we7f", 32'(bif.write_enabled), 1);
        chk("t6_no_hazard", 32'(bif.fetch_hazard), 0);
        chk("t6_read", 32'(bif.pc_bits_read), 32'h7F);
        tick(); #1;
        chk("t6_pend0", 32'(bif.pending), 0);

        // 9 streaming updates across pointer wrap
        for (int i = 0; i < 10; i++) begin
            if (i < 9) offer(1'b1, 7'(32'h40 + i), i[0]);
            else       offer(1'b0, 7'h00, 1'b0);
            #1;
            if (i > 0) begin
                exp_pc = 7'(32'h40 + i - 1);
                chk("wrap_we", 32'(bif.write_enabled), 1);
                chk("wrap_pcw", 32'(bif.pc_bits_write), 32'(exp_pc));
                chk("wrap_out", 32'(bif.outcome), 32'((i - 1) & 1));
                chk("wrap_pend", 32'(bif.pending), 1);
            end
            tick();
        end
        #1;
        chk("wrap_pend0", 32'(bif.pending), 0);
        chk("wrap_we0", 32'(bif.write_enabled), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
